// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED counter controller.
//   CMD_*   : command codes carried on cmd[1:0]
//   DEF_DIV : default prescaler period (one count step per second at 12 MHz)
//   ctrl_state_e : controller state encoding
package led_ctrl_pkg;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_PAUSE = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;

  localparam int unsigned DEF_DIV = 12_000_000;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StDone
  } ctrl_state_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and pulses tick on the DIV-1 cycle.
// Ports:
//   clk, rstn : clock, synchronous active-low reset
//   en        : advance the prescaler this cycle
//   clr       : synchronous clear (wins over en, suppresses tick)
//   tick      : combinational pulse, high while enabled at phase DIV-1
module tick_gen
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] Last = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == Last) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en && !clr && (cnt_q == Last);

endmodule

// File: rtl/led_counter_ctrl.sv
// Command-driven LED counter: IDLE/RUN/PAUSE/DONE state machine stepping an
// LW-bit up/down counter once per DIV clocks, with optional one-shot stop.
// Ports:
//   clk, rstn  : clock, synchronous active-low reset
//   cmd_valid  : command strobe, accepted when cmd_ready is high
//   cmd        : 0 START, 1 STOP, 2 PAUSE (toggle), 3 CLEAR
//   cmd_ready  : command can be accepted this cycle (low in reset and DONE)
//   up         : count direction, sampled on every tick
//   oneshot    : latched on START; stop at terminal value instead of wrapping
//   load_val   : start/clear value (only with LED_CTRL_LOAD_EN defined)
//   leds       : counter value
//   busy       : high in RUN or PAUSE
//   done       : one-cycle pulse when a one-shot run completes
// Build option: define LED_CTRL_LOAD_EN to add the load_val input.
module led_counter_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DIV = DEF_DIV,
  parameter int unsigned LW  = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd,
  output logic          cmd_ready,
  input  logic          up,
  input  logic          oneshot,
`ifdef LED_CTRL_LOAD_EN
  input  logic [LW-1:0] load_val,
`endif
  output logic [LW-1:0] leds,
  output logic          busy,
  output logic          done
);

  ctrl_state_e   state_q;
  logic [LW-1:0] cnt_q;
  logic          oneshot_q;
  logic          busy_q;
  logic          done_q;
  logic          ready_q;

  logic          cmd_acc;
  logic [LW-1:0] start_val;
  logic [LW-1:0] clear_val;
  logic [LW-1:0] step_val;
  logic          at_term;
  logic          tick;
  logic          tick_en;
  logic          tick_clr;

  always_comb begin
    cmd_acc = cmd_valid && ready_q;
`ifdef LED_CTRL_LOAD_EN
    start_val = load_val;
    clear_val = load_val;
`else
    start_val = up ? '0 : '1;
    clear_val = '0;
`endif
    step_val = up ? cnt_q + 1'b1 : cnt_q - 1'b1;
    // Terminal is judged on the value the tick produces, so a run loaded at
    // the terminal value still has to come all the way around again.
    at_term  = up ? (step_val == '1) : (step_val == '0);
    tick_en  = (state_q == StRun);
    // Prescaler sits at 0 outside RUN/PAUSE; every command except PAUSE
    // restarts it, which also discards a coincident tick.
    tick_clr = !(state_q inside {StRun, StPause}) || (cmd_acc && (cmd != CMD_PAUSE));
  end

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rstn (rstn),
    .en   (tick_en),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      oneshot_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (cmd_acc) begin
            if (cmd == CMD_START) begin
              state_q   <= StRun;
              cnt_q     <= start_val;
              oneshot_q <= oneshot;
              busy_q    <= 1'b1;
            end else if (cmd == CMD_CLEAR) begin
              cnt_q <= clear_val;
            end
          end
        end
        StRun, StPause: begin
          // An accepted command always takes priority over a tick.
          if (cmd_acc) begin
            unique case (cmd)
              CMD_START: begin
                state_q   <= StRun;
                cnt_q     <= start_val;
                oneshot_q <= oneshot;
                busy_q    <= 1'b1;
              end
              CMD_STOP: begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end
              CMD_PAUSE: state_q <= (state_q == StRun) ? StPause : StRun;
              CMD_CLEAR: cnt_q <= clear_val;
              default: ;
            endcase
          end else if (tick) begin
            cnt_q <= step_val;
            if (oneshot_q && at_term) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              ready_q <= 1'b0;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign leds      = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_ready = ready_q;

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Self-checking bench for led_counter_ctrl (DIV=4, LW=5): a hand-derived vector
// table, directed corner-case sequences and random commands, all compared
// against a behavioural model of the controller.
module tb_led_counter_ctrl;

  localparam int DIV  = 4;
  localparam int LW   = 5;
  localparam int MAXV = 31;

  localparam logic [1:0] C_START = 2'd0;
  localparam logic [1:0] C_STOP  = 2'd1;
  localparam logic [1:0] C_PAUSE = 2'd2;
  localparam logic [1:0] C_CLEAR = 2'd3;

  localparam int MIdle  = 0;
  localparam int MRun   = 1;
  localparam int MPause = 2;
  localparam int MDone  = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd = 2'd0;
  logic          up = 1'b1;
  logic          oneshot = 1'b0;
  logic          cmd_ready;
  logic          busy;
  logic          done;
  logic [LW-1:0] leds;
`ifdef LED_CTRL_LOAD_EN
  logic [LW-1:0] load_val = '0;
`endif

  always #5 clk = ~clk;

  led_counter_ctrl #(
    .DIV (DIV),
    .LW  (LW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .up        (up),
    .oneshot   (oneshot),
`ifdef LED_CTRL_LOAD_EN
    .load_val  (load_val),
`endif
    .leds      (leds),
    .busy      (busy),
    .done      (done)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int m_state = MIdle;
  int m_presc = 0;
  int m_cnt   = 0;
  bit m_os    = 1'b0;
  bit m_ready = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input logic [1:0] c, input bit u,
                            input bit os);
    bit acc;
    bit tick;
    if (!r) begin
      m_state = MIdle;
      m_presc = 0;
      m_cnt   = 0;
      m_ready = 1'b0;
      return;
    end
    acc  = v && m_ready;
    tick = (m_state == MRun) && (m_presc == DIV - 1);
    if (m_state == MDone) begin
      m_state = MIdle;
    end else if (m_state == MIdle) begin
      m_presc = 0;
      if (acc && c == C_START) begin
        m_state = MRun;
        m_cnt   = u ? 0 : MAXV;
        m_os    = os;
      end else if (acc && c == C_CLEAR) begin
        m_cnt = 0;
      end
    end else begin
      if (m_state == MRun) m_presc = (m_presc + 1) % DIV;
      if (acc) begin
        case (c)
          C_START: begin
            m_state = MRun;
            m_presc = 0;
            m_cnt   = u ? 0 : MAXV;
            m_os    = os;
          end
          C_STOP: begin
            m_state = MIdle;
            m_presc = 0;
          end
          C_PAUSE: m_state = (m_state == MRun) ? MPause : MRun;
          default: begin
            m_cnt   = 0;
            m_presc = 0;
          end
        endcase
      end else if (tick) begin
        m_cnt = u ? (m_cnt + 1) % (MAXV + 1) : (m_cnt + MAXV) % (MAXV + 1);
        if (m_os && m_cnt == (u ? MAXV : 0)) m_state = MDone;
      end
    end
    m_ready = (m_state != MDone);
  endtask

  task automatic drive_edge(input bit r, input bit v, input logic [1:0] c, input bit u,
                            input bit os);
    rstn      = r;
    cmd_valid = v;
    cmd       = c;
    up        = u;
    oneshot   = os;
    @(posedge clk);
    model_step(r, v, c, u, os);
    #1;
  endtask

  task automatic check_model();
    check("leds", int'(leds), m_cnt);
    check("busy", int'(busy), int'(m_state == MRun || m_state == MPause));
    check("done", int'(done), int'(m_state == MDone));
    check("cmd_ready", int'(cmd_ready), int'(m_ready));
  endtask

  task automatic step(input bit r, input bit v, input logic [1:0] c, input bit u,
                      input bit os);
    drive_edge(r, v, c, u, os);
    check_model();
  endtask

  typedef struct {
    bit         r;
    bit         v;
    logic [1:0] c;
    bit         u;
    bit         os;
    int         e_leds;
    bit         e_busy;
    bit         e_done;
    bit         e_ready;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit v, input logic [1:0] c, input bit u,
                              input bit os, input int l, input bit b, input bit d,
                              input bit rd);
    vec_t x;
    x.r = r; x.v = v; x.c = c; x.u = u; x.os = os;
    x.e_leds = l; x.e_busy = b; x.e_done = d; x.e_ready = rd;
    return x;
  endfunction

  vec_t tbl[21];

  initial begin
    int n;
    int prev;
    bit saw_wrap;
    bit r;
    bit v;
    bit u_r;
    bit os;
    logic [1:0] c;

    // Expected outputs after each edge, DIV=4.
    tbl[0]  = mk(0, 0, C_START, 1, 0,  0, 0, 0, 0);  // reset
    tbl[1]  = mk(1, 0, C_START, 1, 0,  0, 0, 0, 1);  // ready rises
    tbl[2]  = mk(1, 1, C_START, 1, 0,  0, 1, 0, 1);  // START up
    tbl[3]  = mk(1, 0, C_START, 1, 0,  0, 1, 0, 1);
    tbl[4]  = mk(1, 0, C_START, 1, 0,  0, 1, 0, 1);
    tbl[5]  = mk(1, 0, C_START, 1, 0,  0, 1, 0, 1);
    tbl[6]  = mk(1, 0, C_START, 1, 0,  1, 1, 0, 1);  // first step
    tbl[7]  = mk(1, 0, C_START, 1, 0,  1, 1, 0, 1);
    tbl[8]  = mk(1, 0, C_START, 1, 0,  1, 1, 0, 1);
    tbl[9]  = mk(1, 0, C_START, 1, 0,  1, 1, 0, 1);
    tbl[10] = mk(1, 1, C_CLEAR, 1, 0,  0, 1, 0, 1);  // CLEAR beats tick
    tbl[11] = mk(1, 0, C_START, 1, 0,  0, 1, 0, 1);
    tbl[12] = mk(1, 0, C_START, 1, 0,  0, 1, 0, 1);
    tbl[13] = mk(1, 0, C_START, 1, 0,  0, 1, 0, 1);
    tbl[14] = mk(1, 0, C_START, 1, 0,  1, 1, 0, 1);  // full period after CLEAR
    tbl[15] = mk(1, 1, C_STOP,  1, 0,  1, 0, 0, 1);  // STOP holds leds
    tbl[16] = mk(1, 1, C_PAUSE, 1, 0,  1, 0, 0, 1);  // PAUSE ignored in IDLE
    tbl[17] = mk(1, 1, C_CLEAR, 1, 0,  0, 0, 0, 1);  // CLEAR in IDLE
    tbl[18] = mk(1, 1, C_START, 0, 0, 31, 1, 0, 1);  // START down loads all-ones
    tbl[19] = mk(1, 1, C_STOP,  0, 0, 31, 0, 0, 1);
    tbl[20] = mk(1, 1, C_CLEAR, 0, 0,  0, 0, 0, 1);

    for (int i = 0; i < 21; i++) begin
      drive_edge(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].u, tbl[i].os);
      check($sformatf("vec%0d_leds", i), int'(leds), tbl[i].e_leds);
      check($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
      check($sformatf("vec%0d_done", i), int'(done), int'(tbl[i].e_done));
      check($sformatf("vec%0d_ready", i), int'(cmd_ready), int'(tbl[i].e_ready));
    end

    // Free-running up count with wrap 31 -> 0
    step(1, 1, C_START, 1, 0);
    saw_wrap = 1'b0;
    prev = int'(leds);
    for (int i = 0; i < 32 * DIV + 8; i++) begin
      step(1, 0, C_START, 1, 0);
      if (prev == MAXV && int'(leds) == 0) saw_wrap = 1'b1;
      prev = int'(leds);
    end
    check("wrap_31_to_0", int'(saw_wrap), 1);
    step(1, 1, C_STOP, 1, 0);

    // Pause mid-period and resume from the frozen phase
    step(1, 1, C_START, 1, 0);
    for (int i = 0; i < 14; i++) step(1, 0, C_START, 1, 0);
    check("pre_pause_leds", int'(leds), 3);
    step(1, 1, C_PAUSE, 1, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, C_START, 1, 0);
      check("paused_leds", int'(leds), 3);
    end
    step(1, 1, C_PAUSE, 1, 0);
    n = 0;
    while (int'(leds) != 4 && n < 4 * DIV) begin
      step(1, 0, C_START, 1, 0);
      n++;
    end
    check("resume_latency", n, DIV - ((14 + 1) % DIV));
    step(1, 1, C_STOP, 1, 0);

    // One-shot up: stop at 31, single done pulse, START ignored during DONE
    step(1, 1, C_CLEAR, 1, 0);
    step(1, 1, C_START, 1, 1);
    n = 0;
    while (!done && n < 40 * DIV) begin
      step(1, 0, C_START, 1, 0);
      n++;
    end
    check("oneshot_up_done", int'(done), 1);
    check("oneshot_up_leds", int'(leds), MAXV);
    check("oneshot_up_busy", int'(busy), 0);
    check("oneshot_up_ready", int'(cmd_ready), 0);
    step(1, 1, C_START, 1, 1);
    check("start_in_done_ignored", int'(busy), 0);
    check("done_one_cycle", int'(done), 0);
    check("oneshot_leds_hold", int'(leds), MAXV);
    check("ready_after_done", int'(cmd_ready), 1);
    step(1, 1, C_START, 1, 0);
    check("restart_busy", int'(busy), 1);
    check("restart_leds", int'(leds), 0);
    step(1, 1, C_STOP, 1, 0);

    // One-shot down: 31 down to 0
    step(1, 1, C_START, 0, 1);
    check("down_start_load", int'(leds), MAXV);
    n = 0;
    while (!done && n < 40 * DIV) begin
      step(1, 0, C_START, 0, 0);
      n++;
    end
    check("oneshot_down_done", int'(done), 1);
    check("oneshot_down_leds", int'(leds), 0);
    step(1, 0, C_START, 0, 0);
    check("oneshot_down_idle", int'(busy), 0);

    // Reset mid-run at 17
    step(1, 1, C_START, 1, 0);
    n = 0;
    while (int'(leds) != 17 && n < 40 * DIV) begin
      step(1, 0, C_START, 1, 0);
      n++;
    end
    check("reached_17", int'(leds), 17);
    step(0, 0, C_START, 1, 0);
    check("rst_leds", int'(leds), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cmd_ready), 0);
    step(1, 0, C_START, 1, 0);
    check("rst_ready_rise", int'(cmd_ready), 1);

    // Random commands, direction flips and occasional resets
    u_r = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 299) != 0);
      v  = ($urandom_range(0, 7) == 0);
      c  = 2'($urandom_range(0, 3));
      os = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) u_r = ~u_r;
      step(r, v, c, u_r, os);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_counter_ctrl.md
# led_counter_ctrl

Command-driven controller that sequences a prescaled LED counter on the iCE40 boards. Replaces the free-running counter-to-LED path with a run/pause/stop state machine, a programmable prescaler, up/down direction and an optional one-shot mode. Sits between the user-input front end (buttons or UART command decoder) and the board LED pins.

## Interface
- `DIV`, default 12_000_000: prescaler period in clk cycles (one count step per DIV cycles); legal range 2..2^24.
- `LW`, default 5: LED counter width.
- `clk`  in  1  system clock (12 MHz on icestick).
- `rstn`  in  1  reset: synchronous, active-low. Clock: `clk`.
- `cmd_valid`  in  1  command strobe.
- `cmd`  in  2  command code: 0 START, 1 STOP, 2 PAUSE (toggle pause/resume), 3 CLEAR.
- `cmd_ready`  out  1  controller can accept a command this cycle.
- `up`  in  1  count direction, sampled on every tick: 1 up, 0 down.
- `oneshot`  in  1  sampled on START: 1 stops at terminal value, 0 wraps.
- `leds`  out  LW  current counter value.
- `busy`  out  1  high in RUN or PAUSE.
- `done`  out  1  one-cycle pulse when a one-shot run completes.

## Operation
- Command accepted iff `cmd_valid && cmd_ready`; otherwise ignored (not queued).
- States: IDLE, RUN, PAUSE, DONE.
- IDLE: prescaler held at 0; `leds` hold. START → RUN, prescaler cleared, counter loaded with 0 (up) or all-ones (down), oneshot latched. CLEAR → counter = 0, stay IDLE. STOP, PAUSE ignored.
- RUN: prescaler counts 0..DIV-1; at DIV-1 it issues a tick and wraps to 0. On tick, counter ±1 modulo 2^LW per `up`. PAUSE → PAUSE. STOP → IDLE (counter holds). CLEAR → counter = 0, prescaler = 0, stay RUN. START → restart as from IDLE.
- PAUSE: prescaler and counter frozen. PAUSE → RUN (prescaler resumes from frozen value). STOP → IDLE. CLEAR → counter = 0, prescaler = 0, stay PAUSE. START → restart.
- One-shot: in RUN with latched oneshot=1, the tick producing terminal value (all-ones if up, 0 if down) moves to DONE; counter holds terminal value.
- DONE: lasts exactly one cycle, `done`=1, then IDLE. `cmd_ready`=0 in DONE.
- Simultaneous tick and accepted command in the same cycle: command wins; the tick is discarded.
- Direction change mid-run takes effect on the next tick; one-shot terminal is evaluated against the current `up`.

## Timing
- Reset (rstn low at an edge): state IDLE, prescaler 0, `leds`=0, `busy`=0, `done`=0, `cmd_ready`=0. `cmd_ready` rises on the first edge with rstn high. Reset mid-run aborts immediately with the same values.
- All outputs registered. A command accepted at edge k is reflected in state, `busy` and `leds` after edge k+1.
- After START at edge k, the first count step appears on `leds` after edge k+DIV+1, then every DIV cycles.
- `done` is high for the cycle after the terminal tick's edge; `busy` falls on that same edge.

## Configuration
- `LED_CTRL_LOAD_EN` defined: adds input `load_val` [LW-1:0]. START loads `load_val` instead of 0/all-ones, and CLEAR loads `load_val` instead of 0. If `load_val` already equals the terminal value in one-shot mode, the run still counts until it reaches the terminal value again (it does not finish immediately).
- Undefined: no `load_val` port; start values as in Operation.

## Structure
- Shared package `led_ctrl_pkg`: command code constants (CMD_START/STOP/PAUSE/CLEAR), state enum type, default DIV constant.
- One sub-module: `tick_gen` (prescaler with enable, sync clear, and tick output, parameter DIV). The state machine and LED counter stay in `led_counter_ctrl`.

## Test plan
- Reset then START (up, oneshot=0), DIV=4 → `leds` 0,1,2… advancing every 4 cycles; wraps 31→0.
- DIV=4, START, run 3 ticks, PAUSE 20 cycles, PAUSE again → `leds` frozen at 3 during the pause; next step to 4 lands exactly DIV minus the prescaler phase after resume.
- oneshot=1, up=1, DIV=2 → `leds` reach 31, `done` pulses once, `busy` falls, `leds` stay 31, START accepted the next cycle.
- up=0, oneshot=1 → START loads 31 and counts down to 0, then `done`.
- CLEAR asserted in the same cycle as a tick while in RUN → `leds`=0 and prescaler restarts; that tick is not applied.
- rstn low for 1 cycle mid-run at `leds`=17 → `leds`=0, `busy`=0, `cmd_ready`=0, then `cmd_ready`=1 on the next cycle.
